// File: rtl/jk_stim_pkg.sv
// ============================================================================
// Module  : jk_stim_pkg
// Brief   : Shared FSM state encoding and JK excitation helper.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package jk_stim_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } jk_state_e;

  // Returns {j,k} that moves a JK flop from cur to nxt.
  function automatic logic [1:0] jk_excite(input logic cur, input logic nxt,
                                           input logic toggle_mode);
    logic [1:0] jk;
    jk = 2'b00;
    if (cur != nxt) begin
      if (toggle_mode) jk = 2'b11;
      else             jk = nxt ? 2'b10 : 2'b01;
    end
    return jk;
  endfunction

endpackage

`default_nettype wire

// File: rtl/jk_err_counter.sv
// ============================================================================
// Module  : jk_err_counter
// Brief   : Saturating failure counter with increment and async clear.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module jk_err_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + C_ONE;
    end
  end

  assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/jk_stim_driver.sv
// ============================================================================
// Module  : jk_stim_driver
// Brief   : Converts target bits into J/K excitation and checks the flop's q/q0.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module jk_stim_driver #(
  parameter bit TOGGLE_MODE = 1'b0,
  parameter int CNT_W       = 8
) (
  input  logic             c,
  input  logic             r,
  input  logic             tgt,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  output logic             j,
  output logic             k,
  input  logic             q_in,
  input  logic             q0_in,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic             busy
);

  import jk_stim_pkg::*;

  jk_state_e state_q;
  logic      cur_q;
  logic      exp_q;
  logic      ready_q;
  logic      j_q;
  logic      k_q;
  logic      err_q;
  logic      busy_q;
  logic      chk_fail_d;

  assign chk_fail_d = (state_q == CHECK) && ((q_in != exp_q) || (q0_in == q_in));

  always_ff @(posedge c or posedge r) begin
    if (r) begin
      state_q <= IDLE;
      cur_q   <= 1'b0;
      exp_q   <= 1'b0;
      ready_q <= 1'b1;
      j_q     <= 1'b0;
      k_q     <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tgt_valid && ready_q) begin
            exp_q      <= tgt;
            {j_q, k_q} <= jk_excite(cur_q, tgt, TOGGLE_MODE);
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= DRIVE;
          end
        end
        DRIVE: begin
          j_q     <= 1'b0;
          k_q     <= 1'b0;
          state_q <= CHECK;
        end
        CHECK: begin
          err_q   <= chk_fail_d;
          // Resync to what the flop actually holds so one fault does not cascade.
          cur_q   <= q_in;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          j_q     <= 1'b0;
          k_q     <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  jk_err_counter #(
    .CNT_W (CNT_W)
  ) u_err_cnt (
    .clk_i (c),
    .rst_i (r),
    .inc_i (chk_fail_d),
    .cnt_o (err_cnt)
  );

  assign tgt_ready = ready_q;
  assign j         = j_q;
  assign k         = k_q;
  assign err       = err_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire
